// File: rtl/demux_pkg.sv
// Shared constants and entry type for the 1-to-2 routing block.
package demux_pkg;

   localparam int unsigned DEMUX_WIDTH = 32;

   localparam logic SEL_OUT0 = 1'b0;
   localparam logic SEL_OUT1 = 1'b1;

   typedef struct packed {
      logic                   sel;
      logic [DEMUX_WIDTH-1:0] data;
   } demux_entry_t;

endpackage

// File: rtl/demux_fifo.sv
// In-order FIFO holding routed entries; Depth must be a power of two, >= 2.
module demux_fifo #(
   parameter int unsigned Width = 33,
   parameter int unsigned Depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] storage_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   // Pointers wrap naturally because Depth is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(Depth); i++) storage_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) storage_q[wr_ptr_q] <= wdata_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata_o = storage_q[rd_ptr_q];
   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/demux32_router.sv
// 1-to-2 valid/ready router with in-order buffering and head-of-line blocking.
// Optional per-output transfer counters are built when DEMUX_STATS_EN is defined.
module demux32_router
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = DEMUX_WIDTH,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_STATS_EN
   ,
   output logic [31:0]      out0_count,
   output logic [31:0]      out1_count
`endif
);

   logic [WIDTH:0]   head;
   logic             head_sel;
   logic [WIDTH-1:0] head_data;
   logic             full, empty, live;
   logic             push, pop, xfer0, xfer1;

   demux_fifo #(
      .Width(WIDTH + 1),
      .Depth(DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .wdata_i ({in_sel, in_data}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign head_sel  = head[WIDTH];
   assign head_data = head[WIDTH-1:0];

   // rst gates the handshakes so the reset cycle itself looks idle.
   assign in_ready = ~rst & ~full;
   assign push     = in_valid & in_ready;
   assign live     = ~rst & ~empty;

   assign out0_valid = live & (head_sel == SEL_OUT0);
   assign out1_valid = live & (head_sel == SEL_OUT1);
   assign out0_data  = out0_valid ? head_data : '0;
   assign out1_data  = out1_valid ? head_data : '0;

   assign xfer0 = out0_valid & out0_ready;
   assign xfer1 = out1_valid & out1_ready;
   assign pop   = xfer0 | xfer1;

`ifdef DEMUX_STATS_EN
   logic [31:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (xfer0) cnt0_q <= cnt0_q + 32'd1;
         if (xfer1) cnt1_q <= cnt1_q + 32'd1;
      end
   end

   assign out0_count = cnt0_q;
   assign out1_count = cnt1_q;
`endif

endmodule

// File: tb/tb_demux32_router.sv
// Scoreboard bench for demux32_router: stimulus queues expected words, a monitor checks them.
module tb_demux32_router;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_sel;
   logic [31:0] in_data;
   logic        out0_valid, out0_ready, out1_valid, out1_ready;
   logic [31:0] out0_data, out1_data;
`ifdef DEMUX_STATS_EN
   logic [31:0] out0_count, out1_count;
`endif

   int nchecks = 0;
   int nerr    = 0;
   logic [32:0] expq[$];

   always #5 clk = ~clk;

   demux32_router dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_data    (in_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data)
`ifdef DEMUX_STATS_EN
      ,
      .out0_count (out0_count),
      .out1_count (out1_count)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic pop_check(input logic port, input logic [31:0] data);
      logic [32:0] e;
      if (expq.size() == 0) begin
         nchecks++;
         nerr++;
         $display("FAIL unexpected_out: port %0d emitted %h, expected nothing", port, data);
      end else begin
         e = expq.pop_front();
         check("out_port", {31'd0, port}, {31'd0, e[32]});
         check("out_data", data, e[31:0]);
      end
   endtask

   // Monitor: sampled at negedge, transfers complete at the following posedge.
   always @(negedge clk) begin
      if (!rst) begin
         if (out0_valid && out0_ready) pop_check(1'b0, out0_data);
         if (out1_valid && out1_ready) pop_check(1'b1, out1_data);
         if (!out0_valid) check("out0_idle_data", out0_data, 32'd0);
         if (!out1_valid) check("out1_idle_data", out1_data, 32'd0);
         check("valid_exclusive", {31'd0, out0_valid & out1_valid}, 32'd0);
      end
   end

   task automatic push(input logic sel, input logic [31:0] data, input bit expect_out,
                       output int waits);
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = data;
      waits    = 0;
      while (waits < 50) begin
         @(negedge clk);
         if (in_ready) break;
         waits++;
      end
      if (waits >= 50) begin
         nchecks++;
         nerr++;
         $display("FAIL push_timeout: in_ready stayed 0, expected 1 within 50 cycles");
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         if (expect_out) expq.push_back({sel, data});
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (expq.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      nchecks++;
      if (expq.size() != 0) begin
         nerr++;
         $display("FAIL drain: %0d words still pending, expected 0", expq.size());
         expq.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      rst        = 1'b1;
      in_valid   = 1'b1;
      in_sel     = 1'b1;
      in_data    = 32'hDEADBEEF;
      out0_ready = 1'b1;
      out1_ready = 1'b1;

      // Reset with in_valid held high
      repeat (2) begin
         @(negedge clk);
         check("rst_in_ready", {31'd0, in_ready}, 32'd0);
         check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
         check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
         check("rst_out0_data", out0_data, 32'd0);
         check("rst_out1_data", out1_data, 32'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_rst_nothing_out0", {31'd0, out0_valid}, 32'd0);
      check("post_rst_nothing_out1", {31'd0, out1_valid}, 32'd0);

      // Basic routing, back-to-back pushes
      @(posedge clk);
      #1 in_valid = 1'b1;
      in_sel  = 1'b0;
      in_data = 32'hAAAAAAAA;
      @(posedge clk);
      expq.push_back({1'b0, 32'hAAAAAAAA});
      #1 in_sel = 1'b1;
      in_data = 32'h55555555;
      @(negedge clk);
      check("basic_out0_valid", {31'd0, out0_valid}, 32'd1);
      check("basic_out0_data", out0_data, 32'hAAAAAAAA);
      check("basic_out1_valid_lo", {31'd0, out1_valid}, 32'd0);
      @(posedge clk);
      expq.push_back({1'b1, 32'h55555555});
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("basic_out1_valid", {31'd0, out1_valid}, 32'd1);
      check("basic_out1_data", out1_data, 32'h55555555);
      check("basic_out0_valid_lo", {31'd0, out0_valid}, 32'd0);
      drain();

      // Fill and backpressure
      out0_ready = 1'b0;
      push(1'b0, 32'hFFFFFFFF, 1'b1, w);
      push(1'b0, 32'h00000000, 1'b1, w);
      @(negedge clk);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 32'h12345678;
      repeat (2) begin
         @(negedge clk);
         check("full_held_off", {31'd0, in_ready}, 32'd0);
         check("stall_out0_valid", {31'd0, out0_valid}, 32'd1);
         check("stall_out0_data", out0_data, 32'hFFFFFFFF);
      end
      @(posedge clk);
      #1 out0_ready = 1'b1;
      push(1'b0, 32'h12345678, 1'b1, w);
      drain();

      // Head-of-line blocking
      out0_ready = 1'b0;
      out1_ready = 1'b1;
      push(1'b0, 32'hA1A1A1A1, 1'b1, w);
      push(1'b1, 32'hB2B2B2B2, 1'b1, w);
      repeat (3) begin
         @(negedge clk);
         check("hol_out1_blocked", {31'd0, out1_valid}, 32'd0);
         check("hol_out0_head", {31'd0, out0_valid}, 32'd1);
      end
      @(posedge clk);
      #1 out0_ready = 1'b1;
      drain();

      // Reset mid-operation discards the buffered word
      out0_ready = 1'b0;
      push(1'b0, 32'hCAFEF00D, 1'b0, w);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      out0_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("midrst_out0_valid", {31'd0, out0_valid}, 32'd0);
         check("midrst_out1_valid", {31'd0, out1_valid}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Streaming: one word per cycle with pointer wrap
      for (int i = 0; i < 8; i++) begin
         push(logic'(i[0]), 32'h10000000 + 32'(i), 1'b1, w);
         check("stream_no_stall", 32'(w), 32'd0);
      end
      drain();

`ifdef DEMUX_STATS_EN
      check("stats_out0_count", out0_count, 32'd4);
      check("stats_out1_count", out1_count, 32'd4);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("stats_out0_cleared", out0_count, 32'd0);
      check("stats_out1_cleared", out1_count, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
